// File: rtl/subunit_ingress_arbiter.sv
// subunit_ingress_arbiter: shares one subunit buffer between four link routers.
// Round-robin grant per TLP, grant locked until the TLP's last word, words
// forwarded through a single registered valid/ready stage.
// Optional feature macro: ARB_TIMEOUT_EN (stall timeout aborts a stuck TLP).

// Per-link request classification: SOP word (arbitration candidate) or stray word.
module subunit_ingress_lane (
  input  logic valid,
  input  logic sop,
  output logic sop_req,
  output logic stray
);
  assign sop_req = valid & sop;
  assign stray   = valid & ~sop;
endmodule

module subunit_ingress_arbiter #(
  parameter int WORD_W    = 40,
  parameter int NUM_LINKS = 4,
  parameter int HDR_WORDS = 3,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_word0,
  input  logic [WORD_W-1:0] in_word1,
  input  logic [WORD_W-1:0] in_word2,
  input  logic [WORD_W-1:0] in_word3,
  input  logic              in_valid0,
  input  logic              in_valid1,
  input  logic              in_valid2,
  input  logic              in_valid3,
  output logic              in_ready0,
  output logic              in_ready1,
  output logic              in_ready2,
  output logic              in_ready3,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err
);
  localparam int SOP_B = WORD_W - 1;

  typedef enum logic {IDLE, XFER} state_t;

  logic [NUM_LINKS-1:0][WORD_W-1:0] words;
  logic [NUM_LINKS-1:0]             valids, sop_req, stray, rdy;

  assign words  = {in_word3, in_word2, in_word1, in_word0};
  assign valids = {in_valid3, in_valid2, in_valid1, in_valid0};

  for (genvar k = 0; k < NUM_LINKS; k++) begin : g_lane
    subunit_ingress_lane u_lane (
      .valid   (valids[k]),
      .sop     (words[k][SOP_B]),
      .sop_req (sop_req[k]),
      .stray   (stray[k])
    );
  end

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d, ptr_q, ptr_d, pick, idx;
  logic [10:0]         rem_q, rem_d, rem_cur, plen, sop_rem;
  logic                sop_seen_q, sop_seen_d;
  logic [WORD_W-1:0]   out_word_q, fwd_word, g_word;
  logic                out_valid_q, err_q, err_d;
  logic                g_valid, fwd_free, mid_sop, accept, found;
`ifdef ARB_TIMEOUT_EN
  logic [8:0]          stall_q, stall_d;
`endif

  assign g_word   = words[grant_q];
  assign g_valid  = valids[grant_q];
  assign fwd_free = !out_valid_q || out_ready;
  // a new SOP from the granted link after its own SOP was taken kills the TLP
  assign mid_sop  = (state_q == XFER) && sop_seen_q && g_valid && g_word[SOP_B];

  // length carried by the SOP word: header only, or header + payload (0 => 1024)
  assign plen    = (g_word[9:0] == 10'd0) ? 11'd1024 : {1'b0, g_word[9:0]};
  assign sop_rem = g_word[30] ? 11'(HDR_WORDS) + plen : 11'(HDR_WORDS);

  // next-state, grant selection, handshakes and error detection
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    sop_seen_d = sop_seen_q;
    err_d      = 1'b0;
    rdy        = '0;
    accept     = 1'b0;
    found      = 1'b0;
    pick       = ptr_q;
    idx        = ptr_q;
    rem_cur    = '0;
    fwd_word   = g_word;
    if (!sop_seen_q) fwd_word[35:34] = grant_q;
`ifdef ARB_TIMEOUT_EN
    stall_d    = stall_q;
`endif
    case (state_q)
      IDLE: begin
        // stray words are swallowed here and flagged
        rdy = stray;
        if (|stray) err_d = 1'b1;
        for (int i = 0; i < NUM_LINKS; i++) begin
          idx = ptr_q + 2'(i);
          if (!found && sop_req[idx]) begin
            found = 1'b1;
            pick  = idx;
          end
        end
        if (found) begin
          grant_d    = pick;
          state_d    = XFER;
          sop_seen_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          stall_d    = '0;
`endif
        end
      end
      XFER: begin
        if (mid_sop) begin
          err_d   = 1'b1;
          state_d = IDLE;
          ptr_d   = grant_q + 2'd1;
        end else begin
          rdy[grant_q] = fwd_free;
          accept       = g_valid && fwd_free;
          if (accept) begin
            rem_cur    = sop_seen_q ? rem_q : sop_rem;
            rem_d      = rem_cur - 11'd1;
            sop_seen_d = 1'b1;
            if (rem_cur == 11'd1) begin
              state_d = IDLE;
              ptr_d   = grant_q + 2'd1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          // only an absent word counts as a stall; buffer backpressure does not
          if (accept) begin
            stall_d = '0;
          end else if (!g_valid) begin
            if (stall_q == 9'(TIMEOUT - 1)) begin
              err_d   = 1'b1;
              state_d = IDLE;
              ptr_d   = grant_q + 2'd1;
              stall_d = '0;
            end else begin
              stall_d = stall_q + 9'd1;
            end
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, pointer, length counter and the registered output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      sop_seen_q  <= 1'b0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      sop_seen_q <= sop_seen_d;
      err_q      <= err_d;
`ifdef ARB_TIMEOUT_EN
      stall_q    <= stall_d;
`endif
      if (accept) begin
        out_word_q  <= fwd_word;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready0 = rdy[0];
  assign in_ready1 = rdy[1];
  assign in_ready2 = rdy[2];
  assign in_ready3 = rdy[3];
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q == XFER);
  assign err       = err_q;
endmodule

// File: tb/tb_subunit_ingress_arbiter.sv
// Scoreboard bench for subunit_ingress_arbiter: link drivers replay per-link
// word queues, a round-robin reference model predicts the output stream.
module tb_subunit_ingress_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] iw [4];
  logic        iv [4];
  logic        ir0, ir1, ir2, ir3;
  logic [39:0] out_word;
  logic        out_valid, out_ready, busy, err;
  logic [1:0]  grant;
  logic [3:0]  irv;

  always #5 clk = ~clk;
  assign irv = {ir3, ir2, ir1, ir0};

  subunit_ingress_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in_word0(iw[0]), .in_word1(iw[1]), .in_word2(iw[2]), .in_word3(iw[3]),
    .in_valid0(iv[0]), .in_valid1(iv[1]), .in_valid2(iv[2]), .in_valid3(iv[3]),
    .in_ready0(ir0), .in_ready1(ir1), .in_ready2(ir2), .in_ready3(ir3),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .busy(busy), .err(err)
  );

  int          checks = 0, errors = 0;
  logic [39:0] drv_q [4][$];
  logic [39:0] mdl_q [4][$];
  int          mlen_q [4][$];
  logic [39:0] exp_q [$];
  int          hs_cyc [$];
  int          ptr_m = 0, err_seen = 0, cyc = 0, or_mode = 0;
  bit          mon_en = 1'b1;

  function automatic logic [39:0] rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[39:0];
  endfunction

  // one TLP for link k: SOP word carries the payload flag and length
  task automatic make_tlp(input int k, input bit pay, input int len10);
    logic [39:0] w;
    int n;
    n = 3 + (pay ? ((len10 == 0) ? 1024 : len10) : 0);
    mlen_q[k].push_back(n);
    for (int j = 0; j < n; j++) begin
      w = rnd_word();
      w[39] = (j == 0);
      if (j == 0) begin
        w[30]  = pay;
        w[9:0] = 10'(len10);
      end
      drv_q[k].push_back(w);
      mdl_q[k].push_back(w);
    end
  endtask

  // reference: whole TLPs served round-robin among links with pending TLPs
  task automatic model_run();
    int k, n;
    bit any;
    logic [39:0] w;
    forever begin
      any = 1'b0;
      for (int i = 0; i < 4 && !any; i++) begin
        k = (ptr_m + i) % 4;
        if (mlen_q[k].size() > 0) begin
          any = 1'b1;
          n = mlen_q[k].pop_front();
          for (int j = 0; j < n; j++) begin
            w = mdl_q[k].pop_front();
            if (j == 0) w[35:34] = 2'(k);
            exp_q.push_back(w);
          end
          ptr_m = (k + 1) % 4;
        end
      end
      if (!any) break;
    end
  endtask

  function automatic bit links_pending();
    return drv_q[0].size() + drv_q[1].size() + drv_q[2].size() + drv_q[3].size() != 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || links_pending()) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s drain timeout pending_exp %0d", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // link drivers + out_ready generator; handshakes sampled at negedge
  initial begin
    bit fire [4];
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin iv[k] = 1'b0; iw[k] = '0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) fire[k] = iv[k] && irv[k];
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
        if (fire[k] && drv_q[k].size() > 0) void'(drv_q[k].pop_front());
        if (drv_q[k].size() > 0) begin iv[k] = 1'b1; iw[k] = drv_q[k][0]; end
        else begin iv[k] = 1'b0; iw[k] = '0; end
      end
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = ~out_ready;
      endcase
    end
  end

  // monitor: pops the scoreboard on every output handshake
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (err) err_seen++;
      if (mon_en && out_valid && out_ready) begin
        hs_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_word unexpected got %0h expected none", out_word);
        end else begin
          e = exp_q.pop_front();
          if (out_word !== e) begin
            errors++;
            $display("FAIL out_word got %0h expected %0h", out_word, e);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int base, e0, n;
    logic [39:0] a, b, w1, b1, b2;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_word", 64'(out_word), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_grant", 64'(grant), 0);
    check("rst_err", 64'(err), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // contention: links 0 and 2 together, one idle arbitration cycle between
    or_mode = 0;
    base = hs_cyc.size();
    make_tlp(0, 1'b0, 0);
    make_tlp(2, 1'b0, 0);
    model_run();
    drain("contention", 200);
    check("contention_words", 64'(hs_cyc.size() - base), 6);
    if (hs_cyc.size() - base == 6) begin
      check("contention_back2back", 64'(hs_cyc[base+2] - hs_cyc[base]), 2);
      check("contention_gap", 64'(hs_cyc[base+3] - hs_cyc[base+2]), 2);
    end

    // fairness: all links, several header-only TLPs each
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) make_tlp(k, 1'b0, 0);
    model_run();
    drain("fairness", 500);

    // payload len 4 with toggling out_ready
    or_mode = 2;
    base = hs_cyc.size();
    make_tlp(1, 1'b1, 4);
    model_run();
    drain("payload_bp", 200);
    check("payload_words", 64'(hs_cyc.size() - base), 7);
    check("payload_busy", 64'(busy), 0);

    // length 0 means 1024 payload words
    or_mode = 1;
    base = hs_cyc.size();
    make_tlp(3, 1'b1, 0);
    model_run();
    drain("len0", 5000);
    check("len0_words", 64'(hs_cyc.size() - base), 1027);

    // randomized batches under random backpressure
    e0 = err_seen;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        n = $urandom_range(0, 3);
        for (int t = 0; t < n; t++)
          make_tlp(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20));
      end
      model_run();
      drain("random_batch", 20000);
    end
    check("random_no_err", 64'(err_seen - e0), 0);

    // stray non-SOP word in IDLE: swallowed, one err pulse, nothing forwarded
    or_mode = 0;
    e0 = err_seen;
    a = rnd_word();
    a[39] = 1'b0;
    drv_q[0].push_back(a);
    drain("stray", 100);
    check("stray_err", 64'(err_seen - e0), 1);

    // mid-packet SOP on link 2 after 2 words: abort, then new TLP accepted
    e0 = err_seen;
    a = rnd_word(); a[39] = 1'b1; a[30] = 1'b0;
    w1 = rnd_word(); w1[39] = 1'b0;
    b = rnd_word(); b[39] = 1'b1; b[30] = 1'b0;
    b1 = rnd_word(); b1[39] = 1'b0;
    b2 = rnd_word(); b2[39] = 1'b0;
    drv_q[2].push_back(a); drv_q[2].push_back(w1);
    drv_q[2].push_back(b); drv_q[2].push_back(b1); drv_q[2].push_back(b2);
    a[35:34] = 2'd2; b[35:34] = 2'd2;
    exp_q.push_back(a); exp_q.push_back(w1);
    exp_q.push_back(b); exp_q.push_back(b1); exp_q.push_back(b2);
    ptr_m = 3;
    drain("midsop", 200);
    check("midsop_err", 64'(err_seen - e0), 1);

    // reset in the middle of a payload
    or_mode = 0;
    base = hs_cyc.size();
    make_tlp(1, 1'b1, 50);
    model_run();
    n = 0;
    while (hs_cyc.size() < base + 10 && n < 200) begin @(posedge clk); n++; end
    check("midrst_progress", 64'(n < 200), 1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv_q[k].delete(); mdl_q[k].delete(); mlen_q[k].delete();
      iv[k] = 1'b0; iw[k] = '0;
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_out_word", 64'(out_word), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_grant", 64'(grant), 0);
    check("midrst_err", 64'(err), 0);
    rst_n = 1'b1;
    ptr_m = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    make_tlp(2, 1'b0, 0);
    model_run();
    drain("post_reset", 200);

`ifdef ARB_TIMEOUT_EN
    // link 0 stalls after its header: timeout abort, link 1 served next
    e0 = err_seen;
    a = rnd_word(); a[39] = 1'b1; a[30] = 1'b1; a[9:0] = 10'd4;
    w1 = rnd_word(); w1[39] = 1'b0;
    b1 = rnd_word(); b1[39] = 1'b0;
    drv_q[0].push_back(a); drv_q[0].push_back(w1); drv_q[0].push_back(b1);
    a[35:34] = 2'd0;
    exp_q.push_back(a); exp_q.push_back(w1); exp_q.push_back(b1);
    make_tlp(1, 1'b0, 0);
    ptr_m = 1;
    model_run();
    drain("timeout", 2000);
    check("timeout_err", 64'(err_seen - e0), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/subunit_ingress_arbiter.md
# subunit_ingress_arbiter

- Shares one subunit buffer between the four input link routers.
- Each router presents 40-bit TLP words for this subunit. The arbiter grants one link per TLP with round-robin fairness, locks the grant until the TLP's last word, and forwards words to the buffer through a registered valid/ready stage.
- One instance sits in front of each subunit buffer.

## Interface

- `WORD_W`, 40: word width; bit 39 = start-of-TLP (SOP), bits 31:0 = data.
- `NUM_LINKS`, 4: requesting links; the design is fixed at 4.
- `HDR_WORDS`, 3: header words per TLP.
- `TIMEOUT`, 256: stall limit in cycles; used only with `ARB_TIMEOUT_EN`.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_word0..3`  in  40 each  word from link k.
- `in_valid0..3`  in  1 each  link k word valid.
- `in_ready0..3`  out  1 each  link k word accepted this cycle when high with `in_valid`.
- `out_word`  out  40  word to subunit buffer.
- `out_valid`  out  1  `out_word` valid.
- `out_ready`  in  1  buffer accepts `out_word`.
- `grant`  out  2  index of the link currently granted.
- `busy`  out  1  a TLP is in progress (state XFER).
- `err`  out  1  one-cycle protocol-error pulse.

## Operation

- **Reset:** all outputs are 0. The round-robin pointer is 0, so link 0 has highest priority. State is IDLE.
- **IDLE state**
  - A link is a candidate when `in_valid` is high and bit 39 of its word is 1.
  - If any candidate exists, register `grant` = first candidate at or after the pointer, wrapping 3→0, and go to XFER.
  - A valid word without SOP on any link is discarded: `in_ready` = 1 for that link, plus an `err` pulse.
- **XFER state**
  - `in_ready[grant]` = `!out_valid || out_ready`. All other `in_ready` are 0, except the non-SOP discard rule above, which does not apply in XFER.
  - Accepting the SOP word loads `remaining` (11 bits).
    - If bit 30 = 0: `remaining` = `HDR_WORDS`.
    - If bit 30 = 1: `remaining` = `HDR_WORDS` + len, where len = bits 9:0 and len 0 means 1024. Maximum `remaining` is 1027.
  - Each accepted word decrements `remaining`. Accepting the word that brings it to 0 ends the TLP.
- **End of TLP:** pointer = `grant`+1 mod 4, and state returns to IDLE.
- **Forwarding**
  - Each accepted word is registered into `out_word` unchanged, except on the SOP word, where bits 35:34 are overwritten with `grant`.
  - `out_valid` holds until `out_ready`.
- **Mid-packet SOP:** a word with bit 39 = 1 from the granted link while `remaining` > 0 and the SOP has already been accepted:
  - the word is not accepted (`in_ready` = 0 that cycle);
  - `err` pulses;
  - the TLP is aborted and state returns to IDLE with the pointer advanced.
  - The offending word is re-arbitrated as a new TLP.
- **Reset mid-TLP:** all state clears and the pending `out_word` is dropped. Links must restart from SOP.
- **Simultaneous events:** when the TLP completes in the same cycle that other links request, the new grant is taken on the following IDLE cycle using the updated pointer.

## Timing

- **Arbitration:** SOP is valid in IDLE at cycle N, `grant` and `busy` are registered at edge N+1, and `in_ready` is high during cycle N+1.
- **Data path:** the first word is accepted at edge N+2 and `out_valid` is high from N+2. Input to output latency is 1 cycle.
- **Throughput:** 1 word/cycle in XFER while `out_ready` stays high.
- **Between TLPs:** minimum gap is one IDLE arbitration cycle.
- **Backpressure:** `out_ready` low holds `out_word` stable and forces `in_ready[grant]` to 0 the same cycle (combinational).
- **`err`:** high for exactly one cycle, registered, in the cycle after the offending event.

## Configuration

- **`ARB_TIMEOUT_EN` defined**
  - A 9-bit stall counter increments each XFER cycle in which `in_valid[grant]` is 0, and clears on any accepted word.
  - On reaching `TIMEOUT`: abort the TLP, pulse `err`, advance the pointer, go to IDLE.
  - A stall on `out_ready` does not count.
- **`ARB_TIMEOUT_EN` undefined:** no counter; the grant is held indefinitely until the TLP completes.

## Test plan

- **Contention:** links 0 and 2 each send a 3-word header-only TLP (bit 30 = 0), SOP in the same cycle after reset → link 0 is forwarded first, then link 2. Bits 35:34 of the two SOP words are 0 and 2. There is 1 idle cycle between TLPs.
- **Fairness:** all four links request continuously with header-only TLPs → grant order is 0,1,2,3,0,…
- **Payload + backpressure:** link 1 sends a TLP with bit 30 = 1 and len = 4, while `out_ready` toggles 1,0,1,0 → exactly 7 words appear on `out_word` in order, with no duplicates or drops. `busy` falls after the 7th acceptance.
- **Length 0:** link 3 sends a TLP with bit 30 = 1 and len = 0 → 1027 words are forwarded before the grant releases.
- **Protocol errors:**
  - Link 2 presents a new SOP after 2 header words → `err` pulses once, the partial TLP is aborted, and the new SOP is later accepted as a fresh TLP.
  - A non-SOP word on link 0 in IDLE → discarded with an `err` pulse.
- **Reset and timeout:** `rst_n` low mid-payload → all outputs are 0 on the next edge. With `ARB_TIMEOUT_EN` and `TIMEOUT` = 256, link 0 stops after its header → `err` pulses 256 stall cycles later and link 1 is granted next.
